// File: rtl/mysoc_pio_poller.sv
// mysoc_pio_poller
//   Avalon-MM read master that periodically polls a PIO slave at offset 0,
//   debounces the sampled value with a consecutive-sample stability filter
//   and presents the committed value plus a one-cycle change pulse.
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   enable        polling enable (level)
//   avm_address   Avalon address, tied to 0
//   avm_read      read strobe, one cycle per request
//   avm_readdata  slave read data; only [DATA_W-1:0] is used
//   value         last committed (stable) sample
//   value_valid   set by the first commit, held until reset
//   changed       one-cycle pulse whenever value is updated
//   poll_count    number of completed samples, wraps at 16 bits
module mysoc_pio_poller #(
  parameter int unsigned DATA_W     = 6,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned POLL_DIV   = 16,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STABLE_CNT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic [31:0]       avm_readdata,
  output logic [DATA_W-1:0] value,
  output logic              value_valid,
  output logic              changed,
  output logic [15:0]       poll_count
);

  localparam int unsigned    TMR_W      = $clog2(POLL_DIV);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(POLL_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
  localparam int             WAIT_I     = (RD_LAT > 1) ? int'(RD_LAT) - 2 : 0;
  localparam logic [1:0]     WAIT_INIT  = 2'(WAIT_I);
  localparam logic [3:0]     STABLE_MAX = 4'(STABLE_CNT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_CAPTURE
  } state_e;

  state_e              state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [1:0]          wait_q, wait_d;
  logic [DATA_W-1:0]   cand_q, cand_d;
  logic [3:0]          stable_q, stable_d;
  logic [DATA_W-1:0]   value_q, value_d;
  logic                valid_q, valid_d;
  logic                changed_q, changed_d;
  logic                read_q, read_d;
  logic [15:0]         pcount_q, pcount_d;
  logic [DATA_W-1:0]   sample;
  logic                unused_rdata;

  assign sample       = avm_readdata[DATA_W-1:0];
  assign unused_rdata = ^avm_readdata[31:DATA_W];

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    wait_d    = wait_q;
    cand_d    = cand_q;
    stable_d  = stable_q;
    value_d   = value_q;
    valid_d   = valid_q;
    changed_d = 1'b0;
    pcount_d  = pcount_q;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          if (timer_q == '0) begin
            state_d = ST_REQ;
            timer_d = TMR_RELOAD;
          end else begin
            timer_d = timer_q - TMR_ONE;
          end
        end
      end
      // Timer keeps running through the transaction, regardless of enable,
      // so the request period stays exactly POLL_DIV cycles.
      ST_REQ: begin
        timer_d = timer_q - TMR_ONE;
        if (RD_LAT == 1) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_WAIT;
          wait_d  = WAIT_INIT;
        end
      end
      ST_WAIT: begin
        timer_d = timer_q - TMR_ONE;
        if (wait_q == '0) begin
          state_d = ST_CAPTURE;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      ST_CAPTURE: begin
        timer_d  = timer_q - TMR_ONE;
        state_d  = ST_IDLE;
        pcount_d = pcount_q + 16'd1;
        if (sample == cand_q) begin
          if (stable_q < STABLE_MAX) begin
            stable_d = stable_q + 4'd1;
          end
        end else begin
          cand_d   = sample;
          stable_d = 4'd1;
        end
        if ((stable_d == STABLE_MAX) && (!valid_q || (sample != value_q))) begin
          value_d   = sample;
          valid_d   = 1'b1;
          changed_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    read_d = (state_d == ST_REQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= TMR_RELOAD;
      wait_q    <= '0;
      cand_q    <= '0;
      stable_q  <= '0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      read_q    <= 1'b0;
      pcount_q  <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      wait_q    <= wait_d;
      cand_q    <= cand_d;
      stable_q  <= stable_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      read_q    <= read_d;
      pcount_q  <= pcount_d;
    end
  end

  assign avm_address = '0;
  assign avm_read    = read_q;
  assign value       = value_q;
  assign value_valid = valid_q;
  assign changed     = changed_q;
  assign poll_count  = pcount_q;

endmodule

// File: doc/mysoc_pio_poller.md
# mysoc_pio_poller

Avalon-MM read master that periodically polls the 6-bit input PIO slave (read latency 1, no waitrequest) at register offset 0. It filters the sampled value with a consecutive-sample stability check and presents a committed value plus change pulse to fabric logic (Booth multiplier operand/control capture). It is the initiator for the input-PIO s1 interface and lets hardware consume the PIO without the CPU.

## Interface
Parameters:
- DATA_W, 6, PIO data width; only readdata[DATA_W-1:0] is used.
- ADDR_W, 2, Avalon address width.
- POLL_DIV, 16, cycles between successive read requests; legal range POLL_DIV >= RD_LAT+3.
- RD_LAT, 1, fixed slave read latency in cycles, 1..4.
- STABLE_CNT, 2, consecutive identical samples required before commit, 1..15.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  polling enable; level.
- avm_address  out  ADDR_W  slave address; always 0.
- avm_read  out  1  read strobe, one cycle per request.
- avm_readdata  in  32  slave read data.
- value  out  DATA_W  last committed (stable) sample.
- value_valid  out  1  high once the first value is committed; stays high until reset.
- changed  out  1  one-cycle pulse when value is updated.
- poll_count  out  16  number of completed samples, wraps 0xFFFF->0.

## Operation
- Reset (reset=1 at clk edge): state IDLE, timer=POLL_DIV-1, avm_read=0, avm_address=0, value=0, value_valid=0, changed=0, candidate=0, stable=0, poll_count=0. Reset overrides everything, including an in-flight read; the late readdata is ignored.
- FSM states: IDLE, REQ, WAIT, CAPTURE.
- IDLE: timer decrements each cycle while enable=1; holds when enable=0. At timer=0 with enable=1, go to REQ and reload timer=POLL_DIV-1. Timer also decrements in REQ/WAIT/CAPTURE so the request period is exactly POLL_DIV cycles.
- REQ: avm_read=1 for exactly this cycle; next state WAIT (RD_LAT-1 extra cycles), or CAPTURE directly when RD_LAT=1.
- WAIT: counts RD_LAT-1 cycles, then CAPTURE.
- CAPTURE: sample s=avm_readdata[DATA_W-1:0]; poll_count+=1; return to IDLE.
  - If s==candidate and stable<STABLE_CNT, stable+=1; otherwise candidate=s, stable=1.
  - Commit when the updated stable equals STABLE_CNT and (value_valid=0 or s!=value). Commit sets value=s, value_valid=1, and pulses changed for one cycle.
  - Stable saturates at STABLE_CNT and never wraps.
- enable falling mid-transaction: the current REQ/WAIT/CAPTURE completes normally; no new request is issued until enable=1 and the timer expires.
- The first commit after reset occurs even when the value is 0.

## Timing
- Request issued in cycle t: slave readdata valid in cycle t+RD_LAT. Sample taken at the end of cycle t+RD_LAT. value and changed are updated in cycle t+RD_LAT+1.
- Consecutive avm_read pulses are exactly POLL_DIV cycles apart while enable=1.
- First request after reset release (enable=1 throughout) occurs POLL_DIV cycles after the first non-reset cycle.
- Minimum input-change-to-changed latency: STABLE_CNT-1 full poll periods plus RD_LAT+1 cycles after the sampling request.
- changed is never high for two consecutive cycles.
- avm_read is never high in two consecutive cycles.
- All outputs are registered.

## Test plan
Defaults for all scenarios: POLL_DIV=8, RD_LAT=1, STABLE_CNT=2.
- Reset/first commit: in_port=0x00, enable=1. Expect avm_read pulses every 8 cycles. After the 2nd sample, value=0x00, value_valid=1, and a single changed pulse.
- Change: after a commit of 0x05, switch the slave to 0x2A. The first 0x2A sample gives no change. On the second sample, value=0x2A, changed pulses in cycle t+2 of that request, and poll_count advances by 2.
- Glitch reject: sample sequence 0x05, 0x11, 0x05 with value=0x05. Expect no changed pulse and value held at 0x05.
- Enable gating: drop enable in the REQ cycle. Expect that read to complete (poll_count+1), then no further avm_read. Restore enable and expect the next request after the timer resumes with its remaining count.
- Reset mid-read: assert reset in the cycle after REQ. Expect all outputs back to reset values and the late readdata ignored (value_valid=0, poll_count=0).
- RD_LAT=3, upper bits: readdata=0xFFFFFFC9. Expect value=0x09 committed at cycle t+4 of the 2nd request.
